// File: rtl/gol_seq_ctrl_pkg.sv
// Shared Game-of-Life controller definitions: sequencer state encoding.
package gol_defs;

  localparam logic [2:0] GOL_ST_IDLE    = 3'd0;
  localparam logic [2:0] GOL_ST_LOAD    = 3'd1;
  localparam logic [2:0] GOL_ST_RUN     = 3'd2;
  localparam logic [2:0] GOL_ST_CAPTURE = 3'd3;
  localparam logic [2:0] GOL_ST_STREAM  = 3'd4;
  localparam logic [2:0] GOL_ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    StIdle    = GOL_ST_IDLE,
    StLoad    = GOL_ST_LOAD,
    StRun     = GOL_ST_RUN,
    StCapture = GOL_ST_CAPTURE,
    StStream  = GOL_ST_STREAM,
    StDone    = GOL_ST_DONE
  } gol_state_e;

endpackage

// File: rtl/gol_seq_ctrl.sv
// Game-of-Life sequencer: loads rows into the cell array, runs it for a
// requested number of generations, then streams the result rows back out.
module gol_seq_ctrl
  import gol_defs::*;
#(
  parameter int unsigned ARR_X_LEN = 8,
  parameter int unsigned ARR_Y_LEN = 8,
  parameter int unsigned GEN_W     = 8,
  localparam int unsigned ROW_W    = (ARR_Y_LEN > 1) ? $clog2(ARR_Y_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [GEN_W-1:0]     gens,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ARR_X_LEN-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ARR_X_LEN-1:0] out_data,
  output logic                 out_last,
  output logic                 arr_run,
  output logic                 arr_inp_load,
  output logic [ROW_W-1:0]     arr_inp_y_addr,
  output logic [ARR_X_LEN-1:0] arr_inp_data,
  output logic                 arr_out_load,
  output logic                 arr_out_shift,
  input  logic [ARR_X_LEN-1:0] arr_out_data
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARR_Y_LEN - 1);

  gol_state_e       state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
  logic             row_last;

  assign row_last = (row_cnt_q == LAST_ROW);

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      row_cnt_q <= '0;
      gen_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    row_cnt_d      = row_cnt_q;
    gen_cnt_d      = gen_cnt_q;
    busy           = 1'b0;
    done           = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    out_last       = 1'b0;
    arr_run        = 1'b0;
    arr_inp_load   = 1'b0;
    arr_inp_y_addr = '0;
    arr_inp_data   = '0;
    arr_out_load   = 1'b0;
    arr_out_shift  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          gen_cnt_d = gens;
          row_cnt_d = '0;
          state_d   = StLoad;
        end
      end

      StLoad: begin
        busy           = 1'b1;
        in_ready       = 1'b1;
        arr_inp_load   = in_valid;
        arr_inp_y_addr = row_cnt_q;
        arr_inp_data   = in_data;
        if (in_valid) begin
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = (gen_cnt_q != '0) ? StRun : StCapture;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      StRun: begin
        busy    = 1'b1;
        arr_run = 1'b1;
        // Guarded decrement; the final run cycle is the one seeing a count of one.
        if (gen_cnt_q != '0) begin
          gen_cnt_d = gen_cnt_q - 1'b1;
        end
        if (gen_cnt_q <= GEN_W'(1)) begin
          state_d = StCapture;
        end
      end

      StCapture: begin
        busy         = 1'b1;
        arr_out_load = 1'b1;
        state_d      = StStream;
      end

      StStream: begin
        busy          = 1'b1;
        out_valid     = 1'b1;
        out_data      = arr_out_data;
        out_last      = row_last;
        arr_out_shift = out_ready;
        if (out_ready) begin
          if (row_last) begin
            row_cnt_d = '0;
            state_d   = StDone;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end

      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_gol_seq_ctrl.sv
// Bench for gol_seq_ctrl: a behavioural cell array sits beside the controller,
// and streamed rows are compared with a Game-of-Life reference model.
module tb_gol_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] gens;
  logic       busy, done;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       arr_run, arr_inp_load, arr_out_load, arr_out_shift;
  logic [2:0] arr_inp_y_addr;
  logic [7:0] arr_inp_data, arr_out_data;

  always #5 clk = ~clk;

  gol_seq_ctrl #(.ARR_X_LEN(8), .ARR_Y_LEN(8), .GEN_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .gens          (gens),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .arr_run       (arr_run),
    .arr_inp_load  (arr_inp_load),
    .arr_inp_y_addr(arr_inp_y_addr),
    .arr_inp_data  (arr_inp_data),
    .arr_out_load  (arr_out_load),
    .arr_out_shift (arr_out_shift),
    .arr_out_data  (arr_out_data)
  );

  int tests  = 0;
  int failed = 0;

  // One Life generation on an 8x8 grid (row y in bits [y*8 +: 8]), dead border.
  function automatic logic [63:0] life_step(input logic [63:0] g);
    logic [63:0] n;
    int cnt, yy, xx;
    n = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if (!(dy == 0 && dx == 0) && yy >= 0 && yy < 8 && xx >= 0 && xx < 8)
              cnt += int'(g[yy*8+xx]);
          end
        end
        n[y*8+x] = (cnt == 3) || (cnt == 2 && g[y*8+x]);
      end
    end
    return n;
  endfunction

  function automatic logic [63:0] life_gens(input logic [63:0] g, input int unsigned n);
    logic [63:0] r;
    r = g;
    for (int i = 0; i < int'(n); i++) r = life_step(r);
    return r;
  endfunction

  // Behavioural cell array plus cumulative activity monitors.
  logic [63:0] grid  = '0;
  logic [63:0] chain = '0;
  int run_cnt = 0, shift_cnt = 0, done_cnt = 0;
  int onehot_bad = 0, shift_bad = 0, load_bad = 0;

  assign arr_out_data = chain[7:0];

  always @(posedge clk) begin
    if (arr_inp_load) grid[int'(arr_inp_y_addr)*8 +: 8] <= arr_inp_data;
    if (arr_run) grid <= life_step(grid);
    if (arr_out_load) chain <= grid;
    if (arr_out_shift) chain <= chain >> 8;
    if (arr_run) run_cnt <= run_cnt + 1;
    if (arr_out_shift) shift_cnt <= shift_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if ($countones({arr_run, arr_inp_load, arr_out_load, arr_out_shift}) > 1)
      onehot_bad <= onehot_bad + 1;
    if (arr_out_shift != (out_valid && out_ready)) shift_bad <= shift_bad + 1;
    if (arr_inp_load != (in_valid && in_ready)) load_bad <= load_bad + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full start/load/run/stream sequence with optional stalls and a stray start.
  task automatic run_seq(input string name, input int unsigned g, input logic [63:0] rows,
                         input logic [63:0] exp, input bit stall_in, input int stall_row,
                         input bit stray_start);
    logic [63:0] got;
    logic [7:0]  held;
    int r_in, r_out, cyc, hold, last_bad, stable_bad;
    int run0, shift0, done0, oh0, sb0, lb0;
    bit seen_done, pulsed;
    got = '0; held = '0;
    r_in = 0; r_out = 0; hold = 0; last_bad = 0; stable_bad = 0;
    seen_done = 0; pulsed = 0;
    run0 = run_cnt; shift0 = shift_cnt; done0 = done_cnt;
    oh0 = onehot_bad; sb0 = shift_bad; lb0 = load_bad;

    @(negedge clk);
    start = 1'b1;
    gens  = 8'(g);
    cyc   = 1;
    for (int k = 0; k < 400 && !seen_done; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) seen_done = 1;
      in_valid = 1'b0;
      if (in_ready && r_in < 8) begin
        in_valid = stall_in ? ((cyc % 2) == 0) : 1'b1;
        in_data  = rows[r_in*8 +: 8];
        if (in_valid) r_in++;
      end
      out_ready = 1'b1;
      if (out_valid && r_out == stall_row && hold < 3) begin
        out_ready = 1'b0;
        if (hold == 0) held = out_data;
        else if (out_data != held) stable_bad++;
        hold++;
      end
      if (out_valid && out_ready) begin
        got[r_out*8 +: 8] = out_data;
        if (out_last != (r_out == 7)) last_bad++;
        r_out++;
      end
      if (stray_start && arr_run && !pulsed) begin
        start  = 1'b1;
        gens   = 8'd77;
        pulsed = 1;
      end
    end
    check({name, " done_seen"}, 64'(seen_done), 64'd1);
    if (stall_in == 0 && stall_row < 0)
      check({name, " latency"}, 64'(cyc), 64'(1 + 8 + g + 1 + 8 + 1));
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 8; r++)
      check($sformatf("%s row%0d", name, r), 64'(got[r*8 +: 8]), 64'(exp[r*8 +: 8]));
    check({name, " run_cycles"}, 64'(run_cnt - run0), 64'(g));
    check({name, " shifts"}, 64'(shift_cnt - shift0), 64'd8);
    check({name, " done_pulses"}, 64'(done_cnt - done0), 64'd1);
    check({name, " out_last"}, 64'(last_bad), 64'd0);
    check({name, " strobe_exclusive"}, 64'(onehot_bad - oh0), 64'd0);
    check({name, " handshake_strobes"}, 64'((shift_bad - sb0) + (load_bad - lb0)), 64'd0);
    if (stall_row >= 0) check({name, " stall_hold"}, 64'(stable_bad), 64'd0);
    if (stray_start) check({name, " stray_start_seen"}, 64'(pulsed), 64'd1);
    check({name, " idle_after"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       name;
    int unsigned g;
    logic [63:0] rows;
    logic [63:0] exp;
    bit          use_model;
  } vec_t;

  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] WALK    = 64'h8040_2010_0804_0201;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [63:0] exp;
    int d0;

    reset_n = 1'b0; start = 1'b0; gens = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    vecs.push_back('{"blinker_g1", 1, BLINK_H, BLINK_V, 1'b0});
    vecs.push_back('{"blinker_g2", 2, BLINK_H, BLINK_H, 1'b0});
    vecs.push_back('{"walk_g0", 0, WALK, WALK, 1'b0});
    for (int i = 0; i < 4; i++) begin
      v.name      = $sformatf("rand%0d", i);
      v.g         = $urandom_range(0, 5);
      v.rows      = {$urandom, $urandom};
      v.exp       = '0;
      v.use_model = 1'b1;
      vecs.push_back(v);
    end

    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, in_ready, out_valid, out_last, out_data, arr_run,
                            arr_inp_load, arr_inp_y_addr, arr_inp_data, arr_out_load,
                            arr_out_shift}, '0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {busy, in_ready, out_valid}, '0);

    foreach (vecs[i]) begin
      exp = vecs[i].use_model ? life_gens(vecs[i].rows, vecs[i].g) : vecs[i].exp;
      run_seq(vecs[i].name, vecs[i].g, vecs[i].rows, exp, 1'b0, -1, 1'b0);
    end

    // Input stalls every other cycle and a three-cycle output stall on row 4.
    run_seq("stalls", 1, BLINK_H, BLINK_V, 1'b1, 4, 1'b0);
    // Start pulsed (with a different gens) while running must not disturb the sequence.
    run_seq("stray_start", 3, WALK, life_gens(WALK, 3), 1'b0, -1, 1'b1);

    // Reset in the middle of streaming: outputs clear at once, no done follows.
    @(negedge clk);
    start = 1'b1; gens = 8'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A;
    for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("mid_reset_streaming", 64'(out_valid), 64'd1);
    @(negedge clk);
    @(negedge clk);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("mid_reset_outputs", {busy, done, in_ready, out_valid, out_last, out_data, arr_run,
                                arr_inp_load, arr_inp_y_addr, arr_inp_data, arr_out_load,
                                arr_out_shift}, '0);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_reset_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_reset_idle", 64'(busy), 64'd0);
    run_seq("after_reset", 2, BLINK_H, BLINK_H, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gol_seq_ctrl.md
GOL_SEQ_CTRL -- requirements
Module: gol_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- ARR_X_LEN, 8, cells per row; row data width.
- ARR_Y_LEN, 8, rows in the array.
- GEN_W, 8, width of the generation count.

REQ-002 Ports SHALL be as listed below; reset is asynchronous and active-low.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load/run/readout sequence.
- gens  in  GEN_W  generation count, sampled on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the sequence completes.
- in_valid  in  1  source offers a row.
- in_ready  out  1  controller accepts a row.
- in_data  in  ARR_X_LEN  row payload, bit j = cell x=j.
- out_valid  out  1  result row available.
- out_ready  in  1  sink accepts the row.
- out_data  out  ARR_X_LEN  result row.
- out_last  out  1  marks row ARR_Y_LEN-1.
- arr_run  out  1  drives array run.
- arr_inp_load  out  1  drives array row load strobe.
- arr_inp_y_addr  out  $clog2(ARR_Y_LEN)  drives array row address.
- arr_inp_data  out  ARR_X_LEN  drives array load data.
- arr_out_load  out  1  snapshot array state into its output chain.
- arr_out_shift  out  1  advance array output chain by one row.
- arr_out_data  in  ARR_X_LEN  array output chain, row 0 position.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN, CAPTURE, STREAM, DONE.
REQ-004 In IDLE, start=1 SHALL latch gens into gen_cnt, clear row_cnt and enter LOAD on the next edge; start in any other state SHALL be ignored.
REQ-005 In LOAD, in_ready SHALL be 1, with arr_inp_load=in_valid, arr_inp_y_addr=row_cnt and arr_inp_data=in_data (combinational, same cycle).
REQ-006 Each in_valid&in_ready beat SHALL increment row_cnt; the beat with row_cnt==ARR_Y_LEN-1 SHALL leave LOAD and clear row_cnt. Idle cycles with in_valid=0 SHALL hold state.
REQ-007 After LOAD, the FSM SHALL enter RUN if the latched gens!=0, otherwise CAPTURE.
REQ-008 In RUN, arr_run SHALL be 1 for exactly gens consecutive cycles, decrementing gen_cnt each cycle, then the FSM SHALL enter CAPTURE.
REQ-009 CAPTURE SHALL last one cycle with arr_out_load=1, then the FSM SHALL enter STREAM.
REQ-010 In STREAM, out_valid SHALL be 1, out_data SHALL equal arr_out_data, and out_last SHALL equal (row_cnt==ARR_Y_LEN-1).
REQ-011 In STREAM, arr_out_shift SHALL equal out_valid&out_ready, and each handshake SHALL increment row_cnt; with out_ready=0, out_data and row_cnt SHALL hold.
REQ-012 The handshake with out_last=1 SHALL enter DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-013 At most one of arr_run, arr_inp_load, arr_out_load and arr_out_shift SHALL be high in any cycle.
REQ-014 Counter wrap: row_cnt SHALL compare against ARR_Y_LEN-1 and never rely on natural overflow; gen_cnt SHALL never underflow.
REQ-015 Latency for gens=G with no stalls: start to done SHALL be 1+ARR_Y_LEN+G+1+ARR_Y_LEN+1 cycles.

Reset
REQ-016 When reset_n=0: state=IDLE, row_cnt=0, gen_cnt=0, and every output 0 (busy, done, in_ready, out_valid, out_last, out_data, all arr_* signals).
REQ-017 Reset mid-sequence SHALL abandon the sequence with no done pulse; array contents are not cleared by this block.

Structure
REQ-018 The state encoding localparams SHALL reside in the shared gol_defs package and be reused by any future GoL controller.
REQ-019 This SHALL be a single module with no sub-module; it instantiates alongside the array, not inside it.

Verification
REQ-020 Blinker, gens=1: rows loaded all 0 except row3=8'h1C -> rows out 0..7 = 00,00,08,08,08,00,00,00; out_last on row 7; one done pulse.
REQ-021 Blinker, gens=2 -> output equals the loaded pattern; arr_run high exactly 2 cycles.
REQ-022 gens=0 with rows 01,02,..,80 -> the same rows are streamed back; arr_run never asserted.
REQ-023 Stalls: in_valid toggled every other cycle, out_ready low for 3 cycles at row 4 -> identical data, shift only on handshakes, row 4 held stable.
REQ-024 start pulsed during RUN -> ignored; reset_n=0 during STREAM -> all outputs 0 next cycle, no done, new start accepted.
